imm_gen_pipe: RTL and testbench

//   Parametrised, pipelined immediate generator for the multi-cycle/pipelined core.

---
 rtl/imm_gen_pipe.sv | 170 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes I/S/B/U/J/zimm immediates and legality,
// registers the result behind a valid/ready handshake with an optional 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter bit          SKID    = 1'b1,
    parameter bit          EN_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam logic [2:0] FmtR = 3'd0;
    localparam logic [2:0] FmtI = 3'd1;
    localparam logic [2:0] FmtS = 3'd2;
    localparam logic [2:0] FmtB = 3'd3;
    localparam logic [2:0] FmtU = 3'd4;
    localparam logic [2:0] FmtJ = 3'd5;
    localparam logic [2:0] FmtZ = 3'd6;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [2:0]      main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;
    logic            main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
    logic            rdy_q, rdy_d;

    logic [31:0]     dec_v32;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic            xfer_in, xfer_out;

    // Every format fits a sign-correct 32-bit value; widening is a plain sign extension.
    always_comb begin
        dec_v32 = '0;
        dec_fmt = FmtR;
        dec_ill = 1'b0;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec_v32 = {{20{instr[31]}}, instr[31:20]};
                dec_fmt = FmtI;
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_v32 = {{20{instr[31]}}, instr[31:20]};
                    dec_fmt = FmtI;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0100011: begin
                dec_v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_fmt = FmtS;
            end
            7'b1100011: begin
                dec_v32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                dec_fmt = FmtB;
            end
            7'b0110111, 7'b0010111: begin
                dec_v32 = {instr[31:12], 12'b0};
                dec_fmt = FmtU;
            end
            7'b1101111: begin
                dec_v32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                dec_fmt = FmtJ;
            end
            7'b1110011: begin
                if (instr[14] && EN_ZIMM) begin
                    dec_v32 = {27'b0, instr[19:15]};
                    dec_fmt = FmtZ;
                end
            end
            7'b0110011, 7'b0001111: dec_fmt = FmtR;
            7'b0111011: dec_ill = (XLEN != 64);
            default:    dec_ill = 1'b1;
        endcase
    end

    assign dec_imm = XLEN'($signed(dec_v32));

    // rdy_q is also low throughout reset, which keeps in_ready low in both modes.
    assign in_ready  = SKID ? rdy_q : (rdy_q & ((state_q != StOne) | out_ready));
    assign out_valid = (state_q != StEmpty);
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_fmt_d = main_fmt_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        skid_ill_d = skid_ill_q;
        unique case (state_q)
            StEmpty: begin
                if (xfer_in) begin
                    main_imm_d = dec_imm;
                    main_fmt_d = dec_fmt;
                    main_ill_d = dec_ill;
                    state_d    = StOne;
                end
            end
            StOne: begin
                if (xfer_in && xfer_out) begin
                    main_imm_d = dec_imm;
                    main_fmt_d = dec_fmt;
                    main_ill_d = dec_ill;
                end else if (xfer_in) begin
                    skid_imm_d = dec_imm;
                    skid_fmt_d = dec_fmt;
                    skid_ill_d = dec_ill;
                    state_d    = StTwo;
                end else if (xfer_out) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (xfer_out) begin
                    main_imm_d = skid_imm_q;
                    main_fmt_d = skid_fmt_q;
                    main_ill_d = skid_ill_q;
                    state_d    = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
        rdy_d = (state_d != StTwo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_imm_q <= '0;
            main_fmt_q <= FmtR;
            main_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_fmt_q <= FmtR;
            skid_ill_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_fmt_q <= main_fmt_d;
            main_ill_q <= main_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_fmt_q <= skid_fmt_d;
            skid_ill_q <= skid_ill_d;
            rdy_q      <= rdy_d;
        end
    end

    assign imm     = main_imm_q;
    assign fmt     = main_fmt_q;
    assign illegal = main_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: decode table against XLEN=32/SKID=1 and XLEN=64/SKID=0 instances,
// then skid-buffer ordering, flush and mid-operation reset sequences on the 32-bit instance.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;

    logic        rdy32, ov32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        rdy64, ov64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SKID(1'b1), .EN_ZIMM(1'b1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .out_valid(ov32), .out_ready(out_ready), .imm(imm32), .fmt(fmt32),
        .illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .SKID(1'b0), .EN_ZIMM(1'b1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .out_valid(ov64), .out_ready(out_ready), .imm(imm64), .fmt(fmt64),
        .illegal(ill64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input int i);
        chk($sformatf("v%0d ov32", i), 64'(ov32), 64'd1);
        chk($sformatf("v%0d imm32", i), 64'(imm32), 64'(tbl[i].imm32));
        chk($sformatf("v%0d fmt32", i), 64'(fmt32), 64'(tbl[i].fmt32));
        chk($sformatf("v%0d ill32", i), 64'(ill32), 64'(tbl[i].ill32));
        chk($sformatf("v%0d ov64", i), 64'(ov64), 64'd1);
        chk($sformatf("v%0d imm64", i), imm64, tbl[i].imm64);
        chk($sformatf("v%0d fmt64", i), 64'(fmt64), 64'(tbl[i].fmt64));
        chk($sformatf("v%0d ill64", i), 64'(ill64), 64'(tbl[i].ill64));
    endtask

    // Fill the 32-bit instance to TWO: A held in main, B in skid.
    task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = a;
        @(negedge clk);
        instr = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        tbl[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
        tbl[2]  = '{32'h3002D073, 32'h00000005, 3'd6, 1'b0, 64'h5, 3'd6, 1'b0};
        tbl[3]  = '{32'h800002B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
        tbl[4]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
        tbl[5]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
        tbl[6]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
        tbl[7]  = '{32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h8, 3'd5, 1'b0};
        tbl[8]  = '{32'hFF9FF06F, 32'hFFFFFFF8, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd5, 1'b0};
        tbl[9]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
        tbl[10] = '{32'h0010809B, 32'h00000000, 3'd0, 1'b1, 64'h1, 3'd1, 1'b0};
        tbl[11] = '{32'h300022F3, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
        tbl[12] = '{32'h00412083, 32'h00000004, 3'd1, 1'b0, 64'h4, 3'd1, 1'b0};
        tbl[13] = '{32'h12345097, 32'h12345000, 3'd4, 1'b0, 64'h12345000, 3'd4, 1'b0};
        tbl[14] = '{32'h0FF0000F, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
        tbl[15] = '{32'h002080BB, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst ov32", 64'(ov32), 64'd0);
        chk("rst rdy32", 64'(rdy32), 64'd0);
        chk("rst imm32", 64'(imm32), 64'd0);
        chk("rst fmt32", 64'(fmt32), 64'd0);
        chk("rst ill32", 64'(ill32), 64'd0);
        chk("rst rdy64", 64'(rdy64), 64'd0);
        chk("rst ov64", 64'(ov64), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst rdy32", 64'(rdy32), 64'd1);
        chk("post-rst rdy64", 64'(rdy64), 64'd1);

        // Streamed decode table, one word per cycle with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            instr    = tbl[i].instr;
            @(negedge clk);
            chk_vec(i);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain ov32", 64'(ov32), 64'd0);

        // Skid: A,B accepted, C stalled until the consumer is ready, order kept
        fill_two(32'hFFF00093, 32'h00412083);
        chk("skid rdy lo", 64'(rdy32), 64'd0);
        chk("skid hold A", 64'(imm32), 64'hFFFFFFFF);
        in_valid = 1'b1;
        instr    = 32'h3002D073;
        @(negedge clk);
        chk("skid stall rdy", 64'(rdy32), 64'd0);
        chk("skid stable A", 64'(imm32), 64'hFFFFFFFF);
        chk("skid stable fmt", 64'(fmt32), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("skid out B", 64'(imm32), 64'd4);
        chk("skid rdy hi", 64'(rdy32), 64'd1);
        @(negedge clk);
        chk("skid out C", 64'(imm32), 64'd5);
        chk("skid C fmt", 64'(fmt32), 64'd6);
        chk("skid C ov", 64'(ov32), 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("skid empty", 64'(ov32), 64'd0);

        // Flush while TWO
        fill_two(32'hFFF00093, 32'h00412083);
        chk("flush pre ov", 64'(ov32), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush ov", 64'(ov32), 64'd0);
        chk("flush rdy", 64'(rdy32), 64'd1);

        // Flush beats a simultaneous input transfer
        in_valid  = 1'b1;
        instr     = 32'h0080006F;
        flush     = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush in ov", 64'(ov32), 64'd0);

        // Asynchronous reset from TWO, between edges
        fill_two(32'hFFF00093, 32'h00412083);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst ov", 64'(ov32), 64'd0);
        chk("async rst imm", 64'(imm32), 64'd0);
        chk("async rst rdy", 64'(rdy32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("re-rst rdy", 64'(rdy32), 64'd1);
        chk("re-rst ov", 64'(ov32), 64'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 32'h0080006F;
        @(negedge clk);
        in_valid = 1'b0;
        chk("re-rst imm", 64'(imm32), 64'd8);
        chk("re-rst fmt", 64'(fmt32), 64'd5);
        chk("re-rst ov1", 64'(ov32), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
